// File: rtl/audio_pkg.sv
// Shared constants, request-FSM state type and sample formatting for the direct-sound path.
package audio_pkg;

  localparam int unsigned DS_FIFO_BYTES = 32;
  localparam int unsigned DS_REQ_THRESH = 16;
  localparam int unsigned DS_WORD_BYTES = 4;
  localparam int unsigned DS_PTR_W      = 5;
  localparam int unsigned DS_LVL_W      = 6;
  localparam int unsigned DS_WAVE_W     = 24;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_REQ  = 2'd1,
    DS_WAIT = 2'd2
  } ds_req_state_e;

  // Places a signed 8-bit sample in the mixer's 24-bit format.
  function automatic logic [DS_WAVE_W-1:0] ds_wave(input logic [7:0] i_sample);
    return {{8{i_sample[7]}}, i_sample, 8'h00};
  endfunction

endpackage

// File: rtl/ds_byte_ring.sv
// 32-byte ring: word-wide push of four bytes (low byte first), byte-wide pop.
module ds_byte_ring
  import audio_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [31:0] i_wdata,
  input  logic        i_pop,
  output logic [7:0]  o_rdata_c
);

  logic [7:0]          r_mem [DS_FIFO_BYTES];
  logic [DS_PTR_W-1:0] r_wr_ptr;
  logic [DS_PTR_W-1:0] r_rd_ptr;

  // Pointers wrap naturally at DS_FIFO_BYTES since the ring is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + DS_PTR_W'(DS_WORD_BYTES);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + DS_PTR_W'(1);
    end
  end

  // Storage carries no reset; unread bytes are never visible because level gates every pop.
  always_ff @(posedge clock) begin
    if (i_push) begin
      for (int unsigned k = 0; k < DS_WORD_BYTES; k++) begin
        r_mem[r_wr_ptr + DS_PTR_W'(k)] <= i_wdata[8*k +: 8];
      end
    end
  end

  assign o_rdata_c = r_mem[r_rd_ptr];

endmodule

// File: rtl/dsound_fifo.sv
// Direct-sound channel FIFO: byte ring, level/flag tracking, timer-driven playback
// and a one-shot DMA refill request.
module dsound_fifo
  import audio_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic [31:0]          fifo_wdata,
  input  logic                 fifo_clear,
  input  logic                 timer_sel,
  input  logic                 tm0_ovf,
  input  logic                 tm1_ovf,
  input  logic                 enable,
  output logic [DS_WAVE_W-1:0] waveout,
  output logic                 sample_valid,
  output logic                 sound_req,
  output logic [DS_LVL_W-1:0]  level,
  output logic                 overflow,
  output logic                 underrun
);

  localparam logic [DS_LVL_W-1:0] LVL_ACCEPT_MAX = DS_LVL_W'(DS_FIFO_BYTES - DS_WORD_BYTES);
  localparam logic [DS_LVL_W-1:0] LVL_THRESH     = DS_LVL_W'(DS_REQ_THRESH);
  localparam logic [DS_LVL_W-1:0] LVL_WORD       = DS_LVL_W'(DS_WORD_BYTES);

  ds_req_state_e       r_state;
  logic                w_pop;
  logic                w_pop_ok;
  logic                w_push;
  logic                w_drop;
  logic [7:0]          w_rdata;
  logic [DS_LVL_W-1:0] w_level_nxt;

  // Fullness is judged on the pre-cycle level, so a same-cycle pop never makes room.
  assign w_pop       = enable & (timer_sel ? tm1_ovf : tm0_ovf) & ~fifo_clear;
  assign w_pop_ok    = w_pop & (level != '0);
  assign w_push      = fifo_wr & ~fifo_clear & (level <= LVL_ACCEPT_MAX);
  assign w_drop      = fifo_wr & ~fifo_clear & (level > LVL_ACCEPT_MAX);
  assign w_level_nxt = level + (w_push ? LVL_WORD : '0) - (w_pop_ok ? DS_LVL_W'(1) : '0);

  ds_byte_ring u_ring (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (fifo_clear),
    .i_push    (w_push),
    .i_wdata   (fifo_wdata),
    .i_pop     (w_pop_ok),
    .o_rdata_c (w_rdata)
  );

  // Level, sticky flags and sample output; waveout survives fifo_clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      waveout      <= '0;
      sample_valid <= 1'b0;
      level        <= '0;
      overflow     <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= w_pop;
      if (fifo_clear) begin
        level    <= '0;
        overflow <= 1'b0;
        underrun <= 1'b0;
      end else begin
        level <= w_level_nxt;
        if (w_drop)             overflow <= 1'b1;
        if (w_pop && !w_pop_ok) underrun <= 1'b1;
        if (w_pop_ok)           waveout  <= ds_wave(w_rdata);
      end
    end
  end

  // Refill request: one pulse per drain below threshold, re-armed once level climbs back above it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= DS_IDLE;
      sound_req <= 1'b0;
    end else if (fifo_clear) begin
      r_state   <= DS_IDLE;
      sound_req <= 1'b0;
    end else begin
      sound_req <= 1'b0;
      case (r_state)
        DS_IDLE: begin
          if (w_pop && (w_level_nxt <= LVL_THRESH)) begin
            r_state   <= DS_REQ;
            sound_req <= 1'b1;
          end
        end
        DS_REQ:  r_state <= DS_WAIT;
        DS_WAIT: if (level > LVL_THRESH) r_state <= DS_IDLE;
        default: r_state <= DS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsound_fifo.sv
// Directed bench for dsound_fifo: vector table for basic playback, hand sequences for corners.
module tb_dsound_fifo;

  logic        clock;
  logic        reset;
  logic        fifo_wr;
  logic [31:0] fifo_wdata;
  logic        fifo_clear;
  logic        timer_sel;
  logic        tm0_ovf;
  logic        tm1_ovf;
  logic        enable;
  logic [23:0] waveout;
  logic        sample_valid;
  logic        sound_req;
  logic [5:0]  level;
  logic        overflow;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;

  dsound_fifo dut (
    .clock        (clock),
    .reset        (reset),
    .fifo_wr      (fifo_wr),
    .fifo_wdata   (fifo_wdata),
    .fifo_clear   (fifo_clear),
    .timer_sel    (timer_sel),
    .tm0_ovf      (tm0_ovf),
    .tm1_ovf      (tm1_ovf),
    .enable       (enable),
    .waveout      (waveout),
    .sample_valid (sample_valid),
    .sound_req    (sound_req),
    .level        (level),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic        pop;
    logic [5:0]  lvl;
    logic [23:0] wave;
    logic        vld;
    logic        req;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One cycle with the given write/timer strobes, then strobes drop.
  task automatic cyc(input logic wr, input logic [31:0] d, input logic p0, input logic p1);
    fifo_wr    = wr;
    fifo_wdata = d;
    tm0_ovf    = p0;
    tm1_ovf    = p1;
    tick();
    fifo_wr = 1'b0;
    tm0_ovf = 1'b0;
    tm1_ovf = 1'b0;
  endtask

  task automatic do_clear(input logic with_wr);
    fifo_clear = 1'b1;
    fifo_wr    = with_wr;
    fifo_wdata = 32'hDEADBEEF;
    tm0_ovf    = with_wr;
    tick();
    fifo_clear = 1'b0;
    fifo_wr    = 1'b0;
    tm0_ovf    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fifo_wr = 1'b0; fifo_wdata = '0; fifo_clear = 1'b0;
    timer_sel = 1'b0; tm0_ovf = 1'b0; tm1_ovf = 1'b0; enable = 1'b1;

    for (int i = 0; i < 4; i++)
      tbl[i] = '{1'b1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b0,
                 6'(4*(i+1)), 24'h0, 1'b0, 1'b0};
    for (int j = 0; j < 16; j++)
      tbl[4+j] = '{1'b0, 32'h0, 1'b1, 6'(15-j), {8'h00, 8'(j), 8'h00}, 1'b1, (j == 0)};

    // Reset state
    repeat (2) tick();
    chk("rst_wave", 32'(waveout), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_req", 32'(sound_req), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_unr", 32'(underrun), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("post_rst_req", 32'(sound_req), 32'h0);

    // Basic playback order and first refill request
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].wr, tbl[i].wdata, tbl[i].pop, 1'b0);
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_wave", i), 32'(waveout), 32'(tbl[i].wave));
      chk($sformatf("tbl%0d_valid", i), 32'(sample_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_req", i), 32'(sound_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_flags", i), 32'({overflow, underrun}), 32'h0);
    end

    // Overflow: 9th word dropped; negative samples sign-extend; then underrun
    do_clear(1'b0);
    for (int k = 0; k < 8; k++)
      cyc(1'b1, {8'(8'h83 + 4*k), 8'(8'h82 + 4*k), 8'(8'h81 + 4*k), 8'(8'h80 + 4*k)}, 1'b0, 1'b0);
    chk("ovf_full_level", 32'(level), 32'd32);
    chk("ovf_before", 32'(overflow), 32'h0);
    cyc(1'b1, 32'h11223344, 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd32);
    chk("ovf_flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("ovf_pop%0d_wave", i), 32'(waveout), {8'h00, 8'hFF, 8'(8'h80 + i), 8'h00});
    end
    chk("ovf_drained", 32'(level), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    chk("unr_before", 32'(underrun), 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("unr_flag", 32'(underrun), 32'h1);
    chk("unr_wave_held", 32'(waveout), 32'hFF9F00);
    chk("unr_valid", 32'(sample_valid), 32'h1);
    chk("unr_level", 32'(level), 32'h0);

    // Clear (with a write and pop attempted during it) resets level, flags, FSM; waveout held
    do_clear(1'b1);
    chk("clr_level", 32'(level), 32'h0);
    chk("clr_flags", 32'({overflow, underrun}), 32'h0);
    chk("clr_valid", 32'(sample_valid), 32'h0);
    chk("clr_wave_held", 32'(waveout), 32'hFF9F00);
    cyc(1'b1, 32'h04030201, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("clr_fsm_idle_req", 32'(sound_req), 32'h1);
    chk("clr_pop_wave", 32'(waveout), 32'h000100);

    // Request FSM: one pulse per drain, re-armed after level rises above 16
    do_clear(1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 32'h0, 1'b0, 1'b0);
    chk("req_lvl20", 32'(level), 32'd20);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("req_a%0d", i), 32'(sound_req), 32'(i == 3));
    end
    chk("req_lvl11", 32'(level), 32'd11);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h0, 1'b0, 1'b0);
      chk($sformatf("req_w%0d", k), 32'(sound_req), 32'h0);
    end
    chk("req_lvl27", 32'(level), 32'd27);
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("req_b%0d", i), 32'(sound_req), 32'(i == 10));
    end
    chk("req_lvl16", 32'(level), 32'd16);

    // Simultaneous write and pop at level 28, then drain across the pointer wrap
    do_clear(1'b0);
    for (int k = 0; k < 7; k++)
      cyc(1'b1, {8'(8'h43 + 4*k), 8'(8'h42 + 4*k), 8'(8'h41 + 4*k), 8'(8'h40 + 4*k)}, 1'b0, 1'b0);
    chk("sim_lvl28", 32'(level), 32'd28);
    cyc(1'b1, 32'h5F5E5D5C, 1'b1, 1'b0);
    chk("sim_level", 32'(level), 32'd31);
    chk("sim_wave", 32'(waveout), 32'h004000);
    chk("sim_ovf", 32'(overflow), 32'h0);
    chk("sim_req", 32'(sound_req), 32'h0);
    for (int i = 1; i < 32; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("sim_pop%0d", i), 32'(waveout), {8'h00, 8'h00, 8'(8'h40 + i), 8'h00});
    end
    chk("sim_empty", 32'(level), 32'h0);

    // Timer select and enable gating
    do_clear(1'b0);
    cyc(1'b1, 32'h0, 1'b0, 1'b0);
    timer_sel = 1'b1;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("tsel_tm0_level", 32'(level), 32'd4);
    chk("tsel_tm0_valid", 32'(sample_valid), 32'h0);
    enable = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("en_off_level", 32'(level), 32'd4);
    chk("en_off_valid", 32'(sample_valid), 32'h0);
    enable = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("tsel_tm1_level", 32'(level), 32'd3);
    chk("tsel_tm1_req", 32'(sound_req), 32'h1);

    // Asynchronous reset during the request pulse
    #2 reset = 1'b1;
    #1;
    chk("arst_req", 32'(sound_req), 32'h0);
    chk("arst_level", 32'(level), 32'h0);
    chk("arst_wave", 32'(waveout), 32'h0);
    chk("arst_valid", 32'(sample_valid), 32'h0);
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("arst_after_req", 32'(sound_req), 32'h0);
    chk("arst_after_level", 32'(level), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dsound_fifo.md
DSOUND_FIFO -- requirements
Module: dsound_fifo

Interface
REQ-001 SHALL have port clock  input  1  system clock (100 MHz); all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port fifo_wr  input  1  one-cycle strobe: CPU/DMA write to FIFO_x register.
REQ-004 SHALL have port fifo_wdata  input  32  written word; byte[7:0] is played first.
REQ-005 SHALL have port fifo_clear  input  1  SOUNDCNT_H FIFO-reset bit (11 for A, 15 for B), level-sensitive.
REQ-006 SHALL have port timer_sel  input  1  SOUNDCNT_H timer select (0 = TM0, 1 = TM1).
REQ-007 SHALL have ports tm0_ovf, tm1_ovf  input  1 each  one-cycle timer overflow pulses.
REQ-008 SHALL have port enable  input  1  OR of channel L/R enable bits; pops ignored when low.
REQ-009 SHALL have port waveout  output  24  current sample, {8 sign bits, sample[7:0], 8'h00}.
REQ-010 SHALL have port sample_valid  output  1  one-cycle pulse when waveout updates.
REQ-011 SHALL have port sound_req  output  1  one-cycle DMA refill request pulse.
REQ-012 SHALL have port level  output  6  bytes held, 0..32.
REQ-013 SHALL have ports overflow, underrun  output  1 each  sticky error flags.

Function
REQ-014 SHALL store 32 bytes in a byte ring with 5-bit write/read pointers wrapping 31->0.
REQ-015 SHALL, on fifo_wr with pre-cycle level <= 28, push 4 bytes (wdata[7:0] first) and add 4 to level.
REQ-016 SHALL, on fifo_wr with pre-cycle level >= 29, drop the whole word and set overflow.
REQ-017 SHALL generate pop = enable & (timer_sel ? tm1_ovf : tm0_ovf).
REQ-018 SHALL, on pop with level > 0, read one byte, decrement level, register it into waveout next cycle and pulse sample_valid.
REQ-019 SHALL, on pop with level == 0, hold waveout, set underrun and pulse sample_valid.
REQ-020 SHALL, on simultaneous accepted write and pop, apply both: level += 3; popped byte is the oldest byte before the write.
REQ-021 SHALL evaluate the full check in REQ-015/016 on pre-cycle level, regardless of a same-cycle pop.
REQ-022 SHALL run request FSM states IDLE, REQ, WAIT.
REQ-023 SHALL transition IDLE->REQ when a pop leaves level <= 16.
REQ-024 SHALL, in REQ, assert sound_req for exactly one cycle, then go to WAIT.
REQ-025 SHALL transition WAIT->IDLE when level > 16; no further sound_req is issued while in WAIT.
REQ-026 SHALL, while fifo_clear is high, zero pointers and level, force FSM to IDLE and ignore writes/pops; waveout is held.
REQ-027 SHALL clear overflow and underrun only on reset or fifo_clear.
REQ-028 SHALL give level, overflow and FSM state one-cycle latency from the causing event; waveout/sample_valid likewise.

Reset
REQ-029 SHALL, on reset, drive waveout=0, sample_valid=0, sound_req=0, level=0, overflow=0, underrun=0, pointers=0, FSM=IDLE.
REQ-030 SHALL abort any in-flight request on reset; no sound_req pulse in the cycle following deassertion.
REQ-031 SHALL leave ring contents undefined after reset, never observable, because level=0.

Structure
REQ-032 SHALL place DS_FIFO_BYTES=32, DS_REQ_THRESH=16 and the FSM state enum in shared package audio_pkg.
REQ-033 SHALL instantiate one sub-module, ds_byte_ring, holding storage and pointers; FSM, level and output are in dsound_fifo.
REQ-034 SHALL be instantiated once per direct-sound channel (A, B) ahead of the direct-sound mixer.

Verification
REQ-035 SHALL cover: 4 writes 0x03020100..0x0F0E0D0C, 16 TM0 pops -> waveout bytes 0x00..0x0F in order, sign-extended; level 16->0.
REQ-036 SHALL cover: 8 writes then a 9th -> level=32, overflow=1, 9th word absent from playback.
REQ-037 SHALL cover: level=20, 4 pops -> one sound_req pulse at the pop reaching 16; 5 more pops produce no further pulses; 4 writes (level>16) then pops to 16 -> second pulse.
REQ-038 SHALL cover: write and pop in the same cycle at level=28 -> write accepted, level=31, oldest byte output.
REQ-039 SHALL cover: pop on empty -> waveout held, underrun=1; fifo_clear pulse -> level=0, flags=0, FSM=IDLE.
REQ-040 SHALL cover: timer_sel=1 with TM0 pulses only -> no pops; reset asserted mid-REQ -> all outputs 0 asynchronously.
